// File: rtl/lru_tick_controller_if.sv
// Handshake bundle between the cache FSM / miss handler and the LRU tick controller.
// Master = cache side, slave = lru_tick_controller.
interface lru_tick_controller_if #(
  parameter int SET_WIDTH = 4,
  parameter int KEY_WIDTH = 2
);
  logic                 touch_valid;
  logic [SET_WIDTH-1:0] touch_set;
  logic [KEY_WIDTH-1:0] touch_way;
  logic                 touch_ready;
  logic                 fill_valid;
  logic [SET_WIDTH-1:0] fill_set;
  logic [KEY_WIDTH-1:0] fill_way;
  logic                 fill_ready;
  logic                 victim_req;
  logic [SET_WIDTH-1:0] victim_set;
  logic                 victim_ack;
  logic [KEY_WIDTH-1:0] victim_way;
  logic                 inval_all;
  logic                 busy;

  modport master (
    output touch_valid, touch_set, touch_way,
    input  touch_ready,
    output fill_valid, fill_set, fill_way,
    input  fill_ready,
    output victim_req, victim_set,
    input  victim_ack, victim_way,
    output inval_all,
    input  busy
  );

  modport slave (
    input  touch_valid, touch_set, touch_way,
    output touch_ready,
    input  fill_valid, fill_set, fill_way,
    output fill_ready,
    input  victim_req, victim_set,
    output victim_ack, victim_way,
    input  inval_all,
    output busy
  );
endinterface

// File: rtl/lru_tick_controller.sv
// Per-set/per-way LRU timestamps, victim selection and tick renormalisation.
// Optional LRU_PERF_EN adds saturating touch_count / victim_count outputs.
module lru_tick_controller #(
  parameter int SET_NUM    = 16,
  parameter int SET_SIZE   = 4,
  parameter int KEY_WIDTH  = $clog2(SET_SIZE),
  parameter int SET_WIDTH  = $clog2(SET_NUM),
  parameter int TICK_WIDTH = 32
) (
  input  logic clk,
  input  logic resetn,
  lru_tick_controller_if.slave bus
`ifdef LRU_PERF_EN
  ,
  output logic [31:0] touch_count,
  output logic [31:0] victim_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    RESP,
    RENORM
  } state_t;

  localparam logic [TICK_WIDTH-1:0] TMAX = '1;

  logic [TICK_WIDTH-1:0] ticks [SET_NUM][SET_SIZE];
  logic [TICK_WIDTH-1:0] snap [SET_SIZE];
  logic [TICK_WIDTH-1:0] rn [SET_SIZE];
  logic [TICK_WIDTH-1:0] now;
  state_t                state;
  logic [SET_WIDTH-1:0]  vset;
  logic [SET_WIDTH-1:0]  rset;
  logic                  pend;
  logic                  busy_q;
  logic                  ack_q;
  logic [KEY_WIDTH-1:0]  way_q;

  logic                  fill_go;
  logic                  touch_go;
  logic                  stamp;
  logic [SET_WIDTH-1:0]  s_set;
  logic [KEY_WIDTH-1:0]  s_way;
  logic [KEY_WIDTH-1:0]  best_key;
  logic [TICK_WIDTH-1:0] best_val;

  assign bus.busy        = busy_q;
  assign bus.fill_ready  = !busy_q;
  assign bus.touch_ready = !busy_q && !bus.fill_valid;
  assign bus.victim_ack  = ack_q;
  assign bus.victim_way  = way_q;

  assign fill_go  = bus.fill_valid && !busy_q;
  assign touch_go = bus.touch_valid && !busy_q
                    && !bus.fill_valid;
  assign stamp    = (fill_go || touch_go)
                    && !bus.inval_all;
  assign s_set    = fill_go ? bus.fill_set
                            : bus.touch_set;
  assign s_way    = fill_go ? bus.fill_way
                            : bus.touch_way;

  // Strict less-than keeps the lowest way on ties.
  always_comb begin
    best_key = '0;
    best_val = snap[0];
    for (int w = 1; w < SET_SIZE; w++) begin
      if (snap[w] < best_val) begin
        best_val = snap[w];
        best_key = KEY_WIDTH'(w);
      end
    end
  end

  // Rank each live tick among the live ticks of the set being walked.
  always_comb begin
    logic [TICK_WIDTH-1:0] rank;
    for (int w = 0; w < SET_SIZE; w++) begin
      rank = '0;
      for (int j = 0; j < SET_SIZE; j++) begin
        if (ticks[rset][j] != '0
            && ticks[rset][j] < ticks[rset][w])
          rank = rank + TICK_WIDTH'(1);
      end
      rn[w] = (ticks[rset][w] == '0) ? '0
            : rank + TICK_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SET_NUM; s++)
        for (int w = 0; w < SET_SIZE; w++)
          ticks[s][w] <= '0;
      for (int w = 0; w < SET_SIZE; w++)
        snap[w] <= '0;
      now    <= TICK_WIDTH'(1);
      state  <= IDLE;
      vset   <= '0;
      rset   <= '0;
      pend   <= 1'b0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      way_q  <= '0;
    end else if (bus.inval_all) begin
      for (int s = 0; s < SET_NUM; s++)
        for (int w = 0; w < SET_SIZE; w++)
          ticks[s][w] <= '0;
      now    <= TICK_WIDTH'(1);
      state  <= IDLE;
      pend   <= 1'b0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend) begin
            state  <= RENORM;
            busy_q <= 1'b1;
            rset   <= '0;
            pend   <= 1'b0;
          end else if (bus.victim_req && !ack_q) begin
            vset  <= bus.victim_set;
            state <= SELECT;
          end
        end
        SELECT: begin
          for (int w = 0; w < SET_SIZE; w++)
            snap[w] <= ticks[vset][w];
          state <= RESP;
        end
        RESP: begin
          way_q <= best_key;
          ack_q <= 1'b1;
          state <= IDLE;
        end
        RENORM: begin
          for (int w = 0; w < SET_SIZE; w++)
            ticks[rset][w] <= rn[w];
          if (rset == SET_WIDTH'(SET_NUM - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            now    <= TICK_WIDTH'(SET_SIZE + 1);
          end else begin
            rset <= rset + SET_WIDTH'(1);
          end
        end
      endcase
      // Saturate so a stamp waiting on renorm never writes an invalid 0.
      if (stamp) begin
        ticks[s_set][s_way] <= now;
        if (now == TMAX)
          pend <= 1'b1;
        else
          now <= now + TICK_WIDTH'(1);
      end
    end
  end

`ifdef LRU_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      touch_count  <= '0;
      victim_count <= '0;
    end else if (bus.inval_all) begin
      touch_count  <= '0;
      victim_count <= '0;
    end else begin
      if (touch_go && touch_count != '1)
        touch_count <= touch_count + 32'd1;
      if (state == RESP && victim_count != '1)
        victim_count <= victim_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lru_tick_controller.sv
// Self-checking bench: default-size instance for hits/fills/victims/flush,
// small-tick instance (TICK_WIDTH=4) for renormalisation.
module tb_lru_tick_controller;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  lru_tick_controller_if #(.SET_WIDTH(4), .KEY_WIDTH(2)) b0();
  lru_tick_controller_if #(.SET_WIDTH(2), .KEY_WIDTH(2)) b1();

`ifdef LRU_PERF_EN
  logic [31:0] tc0, vc0, tc1, vc1;
`endif

  lru_tick_controller #(
    .SET_NUM(16), .SET_SIZE(4), .TICK_WIDTH(32)
  ) d0 (
    .clk(clk), .resetn(resetn), .bus(b0.slave)
`ifdef LRU_PERF_EN
    , .touch_count(tc0), .victim_count(vc0)
`endif
  );

  lru_tick_controller #(
    .SET_NUM(4), .SET_SIZE(4), .TICK_WIDTH(4)
  ) d1 (
    .clk(clk), .resetn(resetn), .bus(b1.slave)
`ifdef LRU_PERF_EN
    , .touch_count(tc1), .victim_count(vc1)
`endif
  );

  typedef enum int { OP_FILL, OP_TOUCH, OP_REQ } op_t;
  typedef struct {
    op_t op;
    int  set;
    int  way;
    int  exp;
  } rec_t;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  int exp_touch = 0;
  int exp_vic = 0;

  task automatic chk(string n, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int d, bit fv, int fs, int fw,
                       bit tv, int ts, int tw,
                       bit vr, int vs, bit inv);
    if (d == 0) begin
      b0.fill_valid  = fv;
      b0.fill_set    = 4'(fs);
      b0.fill_way    = 2'(fw);
      b0.touch_valid = tv;
      b0.touch_set   = 4'(ts);
      b0.touch_way   = 2'(tw);
      b0.victim_req  = vr;
      b0.victim_set  = 4'(vs);
      b0.inval_all   = inv;
    end else begin
      b1.fill_valid  = fv;
      b1.fill_set    = 2'(fs);
      b1.fill_way    = 2'(fw);
      b1.touch_valid = tv;
      b1.touch_set   = 2'(ts);
      b1.touch_way   = 2'(tw);
      b1.victim_req  = vr;
      b1.victim_set  = 2'(vs);
      b1.inval_all   = inv;
    end
  endtask

  function automatic int get_ack(int d);
    return d == 0 ? int'(b0.victim_ack) : int'(b1.victim_ack);
  endfunction

  function automatic int get_way(int d);
    return d == 0 ? int'(b0.victim_way) : int'(b1.victim_way);
  endfunction

  function automatic int get_busy(int d);
    return d == 0 ? int'(b0.busy) : int'(b1.busy);
  endfunction

  task automatic idle(int d);
    drive(d, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic stamp(int d, bit f, int s, int w);
    if (f) drive(d, 1, s, w, 0, 0, 0, 0, 0, 0);
    else   drive(d, 0, 0, 0, 1, s, w, 0, 0, 0);
    if (!f && d == 0) exp_touch++;
    step();
    idle(d);
  endtask

  task automatic wait_ack(int d, string n, int lat);
    int cyc = 0;
    int got;
    while (get_ack(d) == 0 && cyc < 40) begin
      step();
      cyc++;
    end
    if (get_ack(d) == 0) begin
      chk({n, "_timeout"}, 0, 1);
    end else begin
      chk({n, "_lat"}, cyc, lat);
      if (exp_q.size() == 0) begin
        chk({n, "_sb_empty"}, 1, 0);
      end else begin
        got = exp_q.pop_front();
        chk({n, "_way"}, get_way(d), got);
      end
      if (d == 0) exp_vic++;
      idle(d);
      step();
      chk({n, "_pulse"}, get_ack(d), 0);
    end
  endtask

  task automatic victim(int d, int s, int exp, string n);
    drive(d, 0, 0, 0, 0, 0, 0, 1, s, 0);
    exp_q.push_back(exp);
    wait_ack(d, n, 3);
  endtask

  rec_t tbl[$];

  initial begin
    int bc;
    int seen;
    tbl = '{
      '{OP_REQ,   3, 0, 0},
      '{OP_FILL,  2, 0, 0}, '{OP_FILL, 2, 1, 0},
      '{OP_FILL,  2, 2, 0}, '{OP_FILL, 2, 3, 0},
      '{OP_TOUCH, 2, 0, 0}, '{OP_TOUCH, 2, 2, 0},
      '{OP_REQ,   2, 0, 1},
      '{OP_FILL,  5, 0, 0}, '{OP_FILL, 5, 1, 0},
      '{OP_FILL,  5, 3, 0},
      '{OP_REQ,   5, 0, 2},
      '{OP_TOUCH, 2, 1, 0},
      '{OP_REQ,   2, 0, 3},
      '{OP_TOUCH, 2, 3, 0},
      '{OP_REQ,   2, 0, 0},
      '{OP_TOUCH, 7, 2, 0},
      '{OP_REQ,   7, 0, 0},
      '{OP_TOUCH, 7, 0, 0}, '{OP_TOUCH, 7, 1, 0},
      '{OP_TOUCH, 7, 3, 0},
      '{OP_REQ,   7, 0, 2}
    };

    idle(0);
    idle(1);
    resetn = 1'b0;
    repeat (3) step();
    chk("rst_ack",   get_ack(0), 0);
    chk("rst_way",   get_way(0), 0);
    chk("rst_busy",  get_busy(0), 0);
    chk("rst_busy1", get_busy(1), 0);
    chk("rst_fready", int'(b0.fill_ready), 1);
    chk("rst_tready", int'(b0.touch_ready), 1);
`ifdef LRU_PERF_EN
    chk("rst_tc", int'(tc0), 0);
    chk("rst_vc", int'(vc0), 0);
`endif
    resetn = 1'b1;
    step();

    foreach (tbl[i]) begin
      unique case (tbl[i].op)
        OP_FILL:  stamp(0, 1, tbl[i].set, tbl[i].way);
        OP_TOUCH: stamp(0, 0, tbl[i].set, tbl[i].way);
        OP_REQ:   victim(0, tbl[i].set, tbl[i].exp,
                         $sformatf("vec%0d", i));
      endcase
    end

    // Fill and touch together: fill wins, touch is not accepted.
    drive(0, 1, 9, 0, 1, 9, 1, 0, 0, 0);
    #1;
    chk("dual_tready", int'(b0.touch_ready), 0);
    chk("dual_fready", int'(b0.fill_ready), 1);
    step();
    idle(0);
    victim(0, 9, 1, "dual_req");
`ifdef LRU_PERF_EN
    chk("perf_tc", int'(tc0), exp_touch);
    chk("perf_vc", int'(vc0), exp_vic);
`endif

    // Renormalisation on the 4-bit instance; set 0 ends as {9,0,14,11}.
    for (int s = 1; s <= 2; s++)
      for (int w = 0; w < 4; w++)
        stamp(1, 1, s, w);
    stamp(1, 1, 0, 0);
    stamp(1, 1, 3, 0);
    stamp(1, 1, 0, 3);
    stamp(1, 1, 3, 1);
    stamp(1, 1, 3, 2);
    stamp(1, 1, 0, 2);
    chk("rn_pre_busy", get_busy(1), 0);
    stamp(1, 1, 3, 3);
    step();
    chk("rn_busy_rise", get_busy(1), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(1);
    chk("rn_fready", int'(b1.fill_ready), 0);
    bc = 1;
    while (get_busy(1) == 1 && bc < 20) begin
      step();
      if (get_busy(1) == 1) bc++;
      else break;
    end
    chk("rn_busy_len", bc, 4);
    wait_ack(1, "rn_req", 3);
    stamp(1, 0, 0, 1);
    victim(1, 0, 0, "rn_ord_a");
    stamp(1, 0, 0, 0);
    victim(1, 0, 3, "rn_ord_b");
    for (int k = 0; k < 8; k++)
      stamp(1, 1, 1 + k / 4, k % 4);
    step();
    chk("rn_now_lo", get_busy(1), 0);
    stamp(1, 1, 1, 0);
    step();
    chk("rn_now_hi", get_busy(1), 1);
    bc = 0;
    while (get_busy(1) == 1 && bc < 20) begin
      step();
      bc++;
    end
    chk("rn2_done", get_busy(1), 0);

    // Flush while the victim request sits in SELECT.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    idle(0);
    exp_touch = 0;
    exp_vic = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (get_ack(0) != 0) seen = 1;
      step();
    end
    chk("inv_no_ack", seen, 0);
    chk("inv_busy", get_busy(0), 0);
`ifdef LRU_PERF_EN
    chk("inv_vc", int'(vc0), 0);
    chk("inv_tc", int'(tc0), 0);
`endif
    stamp(0, 1, 2, 0);
    drive(0, 1, 2, 2, 1, 2, 1, 0, 0, 0);
    step();
    idle(0);
    stamp(0, 0, 2, 3);
    victim(0, 2, 1, "inv_clear");
`ifdef LRU_PERF_EN
    chk("post_tc", int'(tc0), exp_touch);
    chk("post_vc", int'(vc0), exp_vic);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lru_tick_controller.md
Name: lru_tick_controller

Overview:
- Owns the per-set, per-way access timestamps that feed the combinational LRU min-tree.
- Stamps ways on hits and fills, and serves victim requests from the miss handler through a req/ack handshake.
- Renormalises timestamps before the global tick counter overflows.
- Sits between the cache FSM and the LRU victim-selection tree, one instance per cache.

Parameters:
- SET_NUM, 16: number of cache sets.
- SET_SIZE, 4: ways per set; power of two, at least 2.
- KEY_WIDTH, $clog2(SET_SIZE): way index width.
- SET_WIDTH, $clog2(SET_NUM): set index width.
- TICK_WIDTH, 32: width of each timestamp and of the global counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- touch_valid  in  1  hit access this cycle.
- touch_set  in  SET_WIDTH  set of the hit.
- touch_way  in  KEY_WIDTH  way of the hit.
- touch_ready  out  1  touch accepted when touch_valid && touch_ready.
- fill_valid  in  1  line written into a way.
- fill_set  in  SET_WIDTH  set of the fill.
- fill_way  in  KEY_WIDTH  way of the fill.
- fill_ready  out  1  fill accepted when fill_valid && fill_ready.
- victim_req  in  1  request a victim; held high until victim_ack.
- victim_set  in  SET_WIDTH  set to evict from; stable while victim_req is high.
- victim_ack  out  1  single-cycle pulse; victim_way is valid this cycle.
- victim_way  out  KEY_WIDTH  selected way.
- inval_all  in  1  invalidate all timestamps (cache flush).
- busy  out  1  high while renormalising.

Behaviour:
- Storage: tick[SET_NUM][SET_SIZE] of TICK_WIDTH bits. Tick 0 means invalid / never used. Global counter `now`.
- Reset (asynchronous, resetn low): all ticks 0; now=1; state IDLE; victim_ack=0; victim_way=0; busy=0. Sequential outputs are held at these values while resetn is low.
- Ready rules:
  - fill_ready = !busy.
  - touch_ready = !busy && !fill_valid, so fill has priority and at most one stamp is made per cycle.
- Accepted stamp: tick[set][way] <= now and now <= now+1, same edge.
- Renormalisation trigger: on the edge where an accepted stamp writes now == 2^TICK_WIDTH-1, enter RENORM on the next cycle.
- FSM states: IDLE, SELECT, RESP, RENORM.
  - IDLE:
    - If a renorm is pending, go to RENORM; this has priority over a victim request.
    - Else if victim_req, latch victim_set and go to SELECT.
  - SELECT: copy the SET_SIZE ticks of the latched set into the min-tree input register, then go to RESP.
    - A stamp to the same set in this cycle is not seen by the snapshot; the pre-update value is used.
  - RESP:
    - victim_way <= min-tree result: smallest tick, lowest way index on a tie, so an invalid (0) way wins.
    - victim_ack=1 for exactly one cycle; return to IDLE.
    - Latency from victim_req rising in IDLE to victim_ack is 3 cycles.
  - RENORM:
    - busy=1; a set counter walks set 0..SET_NUM-1, one set per cycle.
    - Each set: nonzero tick t is replaced by 1 + (count of nonzero ticks in the set less than t); zeros stay 0.
    - Relative order is preserved; stamps are unique, so no ties.
    - After the last set: now = SET_SIZE+1, busy=0, return to IDLE.
    - RENORM lasts exactly SET_NUM cycles.
- victim_way holds its last value between acks.
- victim_req deasserted during SELECT/RESP: the ack is still issued; the requester ignores it.
- inval_all (synchronous, highest priority):
  - All ticks 0; now=1; state IDLE; busy=0; pending renorm cleared.
  - An in-flight victim request is aborted with no ack; the requester re-requests.
  - A touch or fill in the same cycle is dropped.
- A touch or fill to an invalid way is legal; it simply stamps.

Optional Feature:
- Macro: LRU_PERF_EN.
- Defined:
  - Adds output touch_count (32 bits), incremented per accepted touch.
  - Adds output victim_count (32 bits), incremented per victim_ack.
  - Both saturate at all-ones, reset to 0, and are cleared by inval_all.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, request victim on set 3 -> victim_ack 3 cycles later with victim_way=0 (all invalid, lowest index).
- Fill set 2 ways 0,1,2,3, then touch way 0 and way 2; request set 2 -> victim_way=1.
- Fill set 5 ways 0,1,3 only; request set 5 -> victim_way=2 (invalid way preferred).
- fill_valid and touch_valid in the same cycle -> touch_ready=0; only the fill stamps; now advances by 1.
- TICK_WIDTH=4, SET_NUM=4, SET_SIZE=4: stamp until now reaches 15 -> busy=1 for exactly 4 cycles; set 0 ticks {9,0,14,11} become {1,0,3,2}; now=5. A victim_req raised during RENORM is acked 3 cycles after busy falls, with the correct way.
- inval_all asserted while in SELECT -> no victim_ack; all ticks read back 0. With LRU_PERF_EN, victim_count is unchanged by the aborted request and touch_count counts only accepted touches.
